lbp_code_packer: RTL and testbench

Downstream stage of the dual-channel LBP output controller. Accepts the two serial LBP result bits (one per redundant channel) each cycle, deserialises them MSB-first into parallel code words, and hands completed word pairs to the next consumer over a valid/ready handshake. Compares the two channel words for fault detection and keeps a saturating mismatch count for the reliability monitor.

---
 rtl/odpc_pkg.sv | 20 ++
 rtl/lbp_shift_channel.sv | 34 +++
 rtl/lbp_code_packer.sv | 145 ++++++++++++++
 tb/tb_lbp_code_packer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/odpc_pkg.sv
// ============================================================
// Module : odpc_pkg
// Brief  : Shared defaults and state encoding for the LBP output path.
// Rev    : 1.0
// ============================================================
`default_nettype none

package odpc_pkg;

    localparam int c_CODE_W_DEFAULT = 8;
    localparam int c_ERR_W_DEFAULT  = 8;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lbp_shift_channel.sv
// ============================================================
// Module : lbp_shift_channel
// Brief  : MSB-first deserialiser for one channel; holds when not enabled.
// Rev    : 1.0
// ============================================================
`default_nettype none

module lbp_shift_channel
    import odpc_pkg::*;
#(
    parameter int CODE_W = c_CODE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_shift_en,
    input  logic              i_bit,
    output logic [CODE_W-1:0] o_data
);

    logic [CODE_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_shift_en) begin
            r_data <= {r_data[CODE_W-2:0], i_bit};
        end
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/lbp_code_packer.sv
// ============================================================
// Module : lbp_code_packer
// Brief  : Packs dual-channel serial LBP bits into word pairs with
//          valid/ready output, mismatch flag and saturating error count.
// Rev    : 1.0
// ============================================================
`default_nettype none

module lbp_code_packer
    import odpc_pkg::*;
#(
    parameter int CODE_W = c_CODE_W_DEFAULT,
    parameter int ERR_W  = c_ERR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic              lbp_bit1,
    input  logic              lbp_bit2,
    input  logic              minmax_on,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code1,
    output logic [CODE_W-1:0] code2,
    output logic              code_mismatch,
    output logic              code_minmax,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                 c_CNT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CODE_W - 1);
    localparam logic [ERR_W-1:0]   c_ERR_MAX = '1;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_tag;
    logic               r_bit_ready;
    logic [CODE_W-1:0]  r_code1;
    logic [CODE_W-1:0]  r_code2;
    logic               r_code_valid;
    logic               r_code_mismatch;
    logic               r_code_minmax;
    logic [ERR_W-1:0]   r_err_count;

    logic [CODE_W-1:0]  w_sr1;
    logic [CODE_W-1:0]  w_sr2;
    logic [CODE_W-1:0]  w_word1;
    logic [CODE_W-1:0]  w_word2;
    logic               w_accept;
    logic               w_last;
    logic               w_slot_free;
    logic               w_load;

    lbp_shift_channel #(.CODE_W(CODE_W)) u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en (w_accept),
        .i_bit      (lbp_bit1),
        .o_data     (w_sr1)
    );

    lbp_shift_channel #(.CODE_W(CODE_W)) u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en (w_accept),
        .i_bit      (lbp_bit2),
        .o_data     (w_sr2)
    );

    assign w_accept    = bit_valid && r_bit_ready;
    assign w_last      = w_accept && (r_bit_cnt == c_LAST);
    assign w_slot_free = !r_code_valid || code_ready;
    assign w_load      = (r_state == COLLECT) ? (w_last && w_slot_free) : code_ready;

    // In COLLECT the final bit is still on the inputs; in FULL it already sits in the shifters.
    assign w_word1 = (r_state == FULL) ? w_sr1 : {w_sr1[CODE_W-2:0], lbp_bit1};
    assign w_word2 = (r_state == FULL) ? w_sr2 : {w_sr2[CODE_W-2:0], lbp_bit2};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= COLLECT;
            r_bit_cnt       <= '0;
            r_tag           <= 1'b0;
            r_bit_ready     <= 1'b0;
            r_code1         <= '0;
            r_code2         <= '0;
            r_code_valid    <= 1'b0;
            r_code_mismatch <= 1'b0;
            r_code_minmax   <= 1'b0;
            r_err_count     <= '0;
        end else begin
            if (w_accept && (r_bit_cnt == '0)) begin
                r_tag <= minmax_on;
            end

            case (r_state)
                COLLECT: begin
                    r_bit_ready <= 1'b1;
                    if (w_last) begin
                        if (w_slot_free) begin
                            r_bit_cnt <= '0;
                        end else begin
                            r_state     <= FULL;
                            r_bit_ready <= 1'b0;
                        end
                    end else if (w_accept) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                FULL: begin
                    if (code_ready) begin
                        r_state     <= COLLECT;
                        r_bit_cnt   <= '0;
                        r_bit_ready <= 1'b1;
                    end
                end
            endcase

            if (w_load) begin
                r_code1         <= w_word1;
                r_code2         <= w_word2;
                r_code_minmax   <= r_tag;
                r_code_mismatch <= (w_word1 != w_word2);
                r_code_valid    <= 1'b1;
                if ((w_word1 != w_word2) && (r_err_count != c_ERR_MAX)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (code_ready) begin
                r_code_valid <= 1'b0;
            end
        end
    end

    assign bit_ready     = r_bit_ready;
    assign code_valid    = r_code_valid;
    assign code1         = r_code1;
    assign code2         = r_code2;
    assign code_mismatch = r_code_mismatch;
    assign code_minmax   = r_code_minmax;
    assign err_count     = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_lbp_code_packer.sv
// ============================================================
// Module : tb_lbp_code_packer
// Brief  : Self-checking bench for lbp_code_packer.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_lbp_code_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       bit_ready;
    logic       lbp_bit1;
    logic       lbp_bit2;
    logic       minmax_on;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] code1;
    logic [7:0] code2;
    logic       code_mismatch;
    logic       code_minmax;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lbp_code_packer #(.CODE_W(8), .ERR_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .lbp_bit1      (lbp_bit1),
        .lbp_bit2      (lbp_bit2),
        .minmax_on     (minmax_on),
        .code_valid    (code_valid),
        .code_ready    (code_ready),
        .code1         (code1),
        .code2         (code2),
        .code_mismatch (code_mismatch),
        .code_minmax   (code_minmax),
        .err_count     (err_count)
    );

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic       mm;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       emis;
        logic       emm;
        logic [7:0] eerr;
    } vec_t;

    typedef struct packed {
        logic [7:0] w1;
        logic [7:0] w2;
        logic       tag;
    } word_t;

    vec_t  vt[5];
    word_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bit_valid = 1'b0;
        lbp_bit1  = 1'b0;
        lbp_bit2  = 1'b0;
        minmax_on = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_bit_ready", 32'(bit_ready), 32'h0);
        chk("rst_code_valid", 32'(code_valid), 32'h0);
        chk("rst_code1", 32'(code1), 32'h0);
        chk("rst_code2", 32'(code2), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after", 32'(bit_ready), 32'h1);
    endtask

    // Streams one word MSB-first, one bit per cycle; minmax_on high only on bit 0 if mm.
    task automatic send_word(input logic [7:0] b1, input logic [7:0] b2, input logic mm,
                             input logic chk_lat);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            lbp_bit1  = b1[7-i];
            lbp_bit2  = b2[7-i];
            minmax_on = (i == 0) ? mm : 1'b0;
            if (chk_lat && i == 7) chk("lat_before_last", 32'(code_valid), 32'h0);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        int         n_words;
        int         m_cnt;
        int         m_mis;
        logic [7:0] m_w1;
        logic [7:0] m_w2;
        logic       m_tag;
        logic       acc;
        logic       hs;
        word_t      w;

        vt[0] = '{8'hB2, 8'hB2, 1'b0, 8'hB2, 8'hB2, 1'b0, 1'b0, 8'd0};
        vt[1] = '{8'hB2, 8'hB3, 1'b0, 8'hB2, 8'hB3, 1'b1, 1'b0, 8'd1};
        vt[2] = '{8'h5A, 8'h5A, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1, 8'd1};
        vt[3] = '{8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'd2};
        vt[4] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd3};

        code_ready = 1'b1;
        do_reset();

        for (int k = 0; k < 5; k++) begin
            send_word(vt[k].b1, vt[k].b2, vt[k].mm, 1'b1);
            chk($sformatf("tbl%0d_valid", k), 32'(code_valid), 32'h1);
            chk($sformatf("tbl%0d_code1", k), 32'(code1), 32'(vt[k].e1));
            chk($sformatf("tbl%0d_code2", k), 32'(code2), 32'(vt[k].e2));
            chk($sformatf("tbl%0d_mis", k), 32'(code_mismatch), 32'(vt[k].emis));
            chk($sformatf("tbl%0d_minmax", k), 32'(code_minmax), 32'(vt[k].emm));
            chk($sformatf("tbl%0d_err", k), 32'(err_count), 32'(vt[k].eerr));
        end

        // Back-pressure: second word parks in the shifters until the consumer takes the first.
        do_reset();
        code_ready = 1'b0;
        send_word(8'hB2, 8'hB2, 1'b1, 1'b0);
        chk("stall_first_valid", 32'(code_valid), 32'h1);
        send_word(8'h3C, 8'h5C, 1'b0, 1'b0);
        chk("stall_bit_ready", 32'(bit_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_code1", 32'(code1), 32'hB2);
            chk("stall_minmax", 32'(code_minmax), 32'h1);
            chk("stall_err", 32'(err_count), 32'h0);
            @(posedge clk); #1;
        end
        code_ready = 1'b1;
        @(posedge clk); #1;
        code_ready = 1'b0;
        chk("xfer_valid", 32'(code_valid), 32'h1);
        chk("xfer_code1", 32'(code1), 32'h3C);
        chk("xfer_code2", 32'(code2), 32'h5C);
        chk("xfer_mis", 32'(code_mismatch), 32'h1);
        chk("xfer_minmax", 32'(code_minmax), 32'h0);
        chk("xfer_err", 32'(err_count), 32'h1);
        chk("xfer_bit_ready", 32'(bit_ready), 32'h1);
        code_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", 32'(code_valid), 32'h0);

        // Error counter saturation.
        do_reset();
        code_ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            send_word(8'hAA, 8'h55, 1'b0, 1'b0);
            if (k == 254) chk("sat_254", 32'(err_count), 32'hFE);
            if (k == 255) chk("sat_255", 32'(err_count), 32'hFF);
        end
        chk("sat_256", 32'(err_count), 32'hFF);

        // Reset mid-word discards partial bits.
        do_reset();
        code_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            lbp_bit1  = 1'b1;
            lbp_bit2  = 1'b1;
            @(posedge clk); #1;
        end
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ready", 32'(bit_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send_word(8'h0F, 8'h0F, 1'b0, 1'b0);
        chk("midrst_valid", 32'(code_valid), 32'h1);
        chk("midrst_code1", 32'(code1), 32'h0F);
        chk("midrst_code2", 32'(code2), 32'h0F);

        // Randomised run against a transaction-level model.
        do_reset();
        code_ready = 1'b0;
        m_cnt   = 0;
        m_mis   = 0;
        m_w1    = '0;
        m_w2    = '0;
        m_tag   = 1'b0;
        n_words = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            bit_valid  = ($urandom % 4) != 0;
            lbp_bit1   = 1'($urandom);
            lbp_bit2   = (($urandom % 8) == 0) ? ~lbp_bit1 : lbp_bit1;
            minmax_on  = 1'($urandom);
            code_ready = 1'($urandom);
            @(negedge clk);
            acc = bit_valid && bit_ready;
            hs  = code_valid && code_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_word", 32'h1, 32'h0);
                end else begin
                    w = q.pop_front();
                    n_words++;
                    if (w.w1 != w.w2) m_mis++;
                    chk("rand_code1", 32'(code1), 32'(w.w1));
                    chk("rand_code2", 32'(code2), 32'(w.w2));
                    chk("rand_mis", 32'(code_mismatch), 32'(w.w1 != w.w2));
                    chk("rand_minmax", 32'(code_minmax), 32'(w.tag));
                    chk("rand_err", 32'(err_count), (m_mis > 255) ? 32'd255 : 32'(m_mis));
                end
            end
            if (acc) begin
                if (m_cnt == 0) m_tag = minmax_on;
                m_w1 = {m_w1[6:0], lbp_bit1};
                m_w2 = {m_w2[6:0], lbp_bit2};
                m_cnt++;
                if (m_cnt == 8) begin
                    q.push_back('{m_w1, m_w2, m_tag});
                    m_cnt = 0;
                    chk("rand_backlog", 32'(q.size() <= 2), 32'h1);
                end
            end
            @(posedge clk); #1;
        end
        chk("rand_word_count", 32'(n_words >= 100), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
